// File: rtl/flappy_collide_score_if.sv
// Signal bundle between the game-rule stage and its neighbours: the X-store
// geometry and player controls in, the counters, freeze pulse and state out.
interface flappy_collide_score_if;
    logic       Start;
    logic       Ack;
    logic [9:0] bird_y;
    logic [2:0] pipe_idx;
    logic [9:0] pipe_xl;
    logic [9:0] pipe_xr;
    logic [9:0] gap_top;
    logic [9:0] gap_bot;
    logic [2:0] coin_idx;
    logic [9:0] coin_xl;
    logic [9:0] coin_xr;
    logic [9:0] coin_yt;
    logic [9:0] coin_yb;
    logic       Stop;
    logic [7:0] score;
    logic [7:0] coins;
    logic [7:0] best;
    logic [4:0] coin_taken;
    logic       Q_Idle;
    logic       Q_Run;
    logic       Q_Over;

    modport master (
        output Start, Ack, bird_y, pipe_idx, pipe_xl, pipe_xr, gap_top, gap_bot,
               coin_idx, coin_xl, coin_xr, coin_yt, coin_yb,
        input  Stop, score, coins, best, coin_taken, Q_Idle, Q_Run, Q_Over
    );

    modport slave (
        input  Start, Ack, bird_y, pipe_idx, pipe_xl, pipe_xr, gap_top, gap_bot,
               coin_idx, coin_xl, coin_xr, coin_yt, coin_yb,
        output Stop, score, coins, best, coin_taken, Q_Idle, Q_Run, Q_Over
    );
endinterface

// File: rtl/flappy_collide_score.sv
// Game-rule stage: bird/pipe/coin collision, BCD pipe and coin counters,
// session high score, and the run/over state machine that freezes scrolling.
module flappy_collide_score #(
    parameter int BIRD_X_L = 210,
    parameter int BIRD_W   = 20,
    parameter int BIRD_H   = 16,
    parameter int GROUND_Y = 464
) (
    input  logic                   clk,
    input  logic                   reset,
    flappy_collide_score_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X_L);
    localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X_L + BIRD_W);
    localparam logic [10:0] BIRD_HGT   = 11'(BIRD_H);
    localparam logic [10:0] GROUND_ROW = 11'(GROUND_Y);
    localparam logic [2:0]  START_IDX  = 3'd2;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    state_t     state_reg, state_next;
    logic [7:0] score_reg, score_next;
    logic [7:0] coins_reg, coins_next;
    logic [7:0] best_reg, best_next;
    logic [2:0] prev_pipe_reg, prev_pipe_next;
    logic [2:0] prev_coin_reg, prev_coin_next;
    logic [4:0] taken_reg, taken_next;
    logic       stop_reg, stop_next;
    logic       q_idle_reg, q_run_reg, q_over_reg;

    logic [10:0] bird_top;
    logic [10:0] bird_bot;
    logic        hx;
    logic        hit;
    logic        coin_box;
    logic        cov;
    logic [4:0]  coin_mask;
    logic [4:0]  prev_mask;
    logic [4:0]  taken_set;
    logic [4:0]  taken_clr;
    logic        taken_wipe;

    // All geometry is widened to 11 bits so bottom edges near 1023 never wrap.
    always_comb begin
        bird_top = {1'b0, bus.bird_y};
        bird_bot = bird_top + BIRD_HGT;
        hx       = ({1'b0, bus.pipe_xl} < BIRD_RIGHT) && ({1'b0, bus.pipe_xr} > BIRD_LEFT);
        hit      = (hx && ((bird_top < {1'b0, bus.gap_top}) || (bird_bot > {1'b0, bus.gap_bot})))
                   || (bird_bot >= GROUND_ROW);
        coin_box = ({1'b0, bus.coin_xl} < BIRD_RIGHT) && ({1'b0, bus.coin_xr} > BIRD_LEFT)
                   && ({1'b0, bus.coin_yt} < bird_bot) && ({1'b0, bus.coin_yb} > bird_top);
        // Shifting past bit 4 yields an empty mask, so stray indices touch nothing.
        coin_mask = 5'b00001 << bus.coin_idx;
        prev_mask = 5'b00001 << prev_coin_reg;
        cov       = coin_box && ((taken_reg & coin_mask) == 5'b00000);
    end

    always_comb begin
        state_next     = state_reg;
        score_next     = score_reg;
        coins_next     = coins_reg;
        best_next      = best_reg;
        prev_pipe_next = prev_pipe_reg;
        prev_coin_next = prev_coin_reg;
        stop_next      = 1'b0;
        taken_set      = 5'b00000;
        taken_clr      = 5'b00000;
        taken_wipe     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.Start) begin
                    state_next     = RUN;
                    score_next     = 8'h00;
                    coins_next     = 8'h00;
                    taken_wipe     = 1'b1;
                    prev_pipe_next = START_IDX;
                    prev_coin_next = START_IDX;
                end
            end
            RUN: begin
                if (bus.pipe_idx != prev_pipe_reg) begin
                    score_next = bcd_inc(score_reg);
                end
                if (bus.coin_idx != prev_coin_reg) begin
                    taken_clr = prev_mask;
                end
                if (cov) begin
                    coins_next = bcd_inc(coins_reg);
                    taken_set  = coin_mask;
                end
                prev_pipe_next = bus.pipe_idx;
                prev_coin_next = bus.coin_idx;
                // The best compare sees this cycle's score increment.
                if (hit) begin
                    state_next = OVER;
                    stop_next  = 1'b1;
                    if (score_next > best_reg) begin
                        best_next = score_next;
                    end
                end
            end
            OVER: begin
                if (bus.Ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A recycled coin reappears unless it is collected again in the same cycle.
    for (genvar gi = 0; gi < 5; gi++) begin : g_taken
        assign taken_next[gi] = taken_set[gi]
                              | (taken_reg[gi] & ~taken_clr[gi] & ~taken_wipe);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            score_reg     <= 8'h00;
            coins_reg     <= 8'h00;
            best_reg      <= 8'h00;
            prev_pipe_reg <= START_IDX;
            prev_coin_reg <= START_IDX;
            taken_reg     <= 5'b00000;
            stop_reg      <= 1'b0;
            q_idle_reg    <= 1'b1;
            q_run_reg     <= 1'b0;
            q_over_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            score_reg     <= score_next;
            coins_reg     <= coins_next;
            best_reg      <= best_next;
            prev_pipe_reg <= prev_pipe_next;
            prev_coin_reg <= prev_coin_next;
            taken_reg     <= taken_next;
            stop_reg      <= stop_next;
            q_idle_reg    <= (state_next == IDLE);
            q_run_reg     <= (state_next == RUN);
            q_over_reg    <= (state_next == OVER);
        end
    end

    assign bus.Stop       = stop_reg;
    assign bus.score      = score_reg;
    assign bus.coins      = coins_reg;
    assign bus.best       = best_reg;
    assign bus.coin_taken = taken_reg;
    assign bus.Q_Idle     = q_idle_reg;
    assign bus.Q_Run      = q_run_reg;
    assign bus.Q_Over     = q_over_reg;

endmodule

// File: tb/tb_flappy_collide_score.sv
// Scoreboard bench: a rule-level game model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_flappy_collide_score;

    localparam int BX_L = 210;
    localparam int BX_R = 230;
    localparam int BH   = 16;
    localparam int GY   = 464;

    logic clk;
    logic reset;
    flappy_collide_score_if bus ();

    flappy_collide_score #(
        .BIRD_X_L(210), .BIRD_W(20), .BIRD_H(16), .GROUND_Y(464)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;      // {over, run, idle}
        logic       stop;
        logic [7:0] score;
        logic [7:0] coins;
        logic [7:0] best;
        logic [4:0] taken;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference game state held as plain integers.
    int m_state;   // 0 idle, 1 run, 2 over
    int m_score, m_coins, m_best, m_prev_pipe, m_prev_coin;
    bit m_taken[5];
    bit m_stop;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_step();
        int  by, bb, pi, ci;
        bit  hx, hit, cov;
        if (reset) begin
            m_state = 0; m_score = 0; m_coins = 0; m_best = 0;
            m_prev_pipe = 2; m_prev_coin = 2; m_stop = 0;
            for (int k = 0; k < 5; k++) m_taken[k] = 0;
        end else begin
            m_stop = 0;
            by = int'(bus.bird_y);
            bb = by + BH;
            pi = int'(bus.pipe_idx);
            ci = int'(bus.coin_idx);
            if (m_state == 0) begin
                if (bus.Start) begin
                    m_state = 1; m_score = 0; m_coins = 0;
                    m_prev_pipe = 2; m_prev_coin = 2;
                    for (int k = 0; k < 5; k++) m_taken[k] = 0;
                end
            end else if (m_state == 1) begin
                hx  = int'(bus.pipe_xl) < BX_R && int'(bus.pipe_xr) > BX_L;
                hit = (hx && (by < int'(bus.gap_top) || bb > int'(bus.gap_bot))) || bb >= GY;
                cov = int'(bus.coin_xl) < BX_R && int'(bus.coin_xr) > BX_L
                      && int'(bus.coin_yt) < bb && int'(bus.coin_yb) > by
                      && !(ci < 5 && m_taken[ci]);
                if (pi != m_prev_pipe) m_score = (m_score + 1) % 100;
                if (ci != m_prev_coin && m_prev_coin < 5) m_taken[m_prev_coin] = 0;
                if (cov) begin
                    m_coins = (m_coins + 1) % 100;
                    if (ci < 5) m_taken[ci] = 1;
                end
                m_prev_pipe = pi;
                m_prev_coin = ci;
                if (hit) begin
                    m_state = 2;
                    m_stop  = 1;
                    if (m_score > m_best) m_best = m_score;
                end
            end else begin
                if (bus.Ack) m_state = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st    = (m_state == 0) ? 3'b001 : (m_state == 1) ? 3'b010 : 3'b100;
        e.stop  = m_stop;
        e.score = to_bcd(m_score);
        e.coins = to_bcd(m_coins);
        e.best  = to_bcd(m_best);
        for (int k = 0; k < 5; k++) e.taken[k] = m_taken[k];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%h expected=%h", name, txn, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            txn++;
            $display("txn %0d: state=%b stop=%b score=%h coins=%h best=%h taken=%b",
                     txn, {bus.Q_Over, bus.Q_Run, bus.Q_Idle}, bus.Stop,
                     bus.score, bus.coins, bus.best, bus.coin_taken);
            check("state", 8'({bus.Q_Over, bus.Q_Run, bus.Q_Idle}), 8'(e.st));
            check("stop",  8'(bus.Stop), 8'(e.stop));
            check("score", bus.score, e.score);
            check("coins", bus.coins, e.coins);
            check("best",  bus.best, e.best);
            check("coin_taken", 8'(bus.coin_taken), 8'(e.taken));
        end
    end

    task automatic set_far();
        bus.bird_y  = 10'd200;
        bus.pipe_xl = 10'd400; bus.pipe_xr = 10'd461;
        bus.gap_top = 10'd150; bus.gap_bot = 10'd300;
        bus.coin_xl = 10'd500; bus.coin_xr = 10'd520;
        bus.coin_yt = 10'd0;   bus.coin_yb = 10'd10;
    endtask

    task automatic start_run();
        bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    endtask

    task automatic step_pipe(input int n);
        for (int k = 0; k < n; k++) begin
            bus.pipe_idx = 3'((int'(bus.pipe_idx) + 1) % 5);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Start = 1'b0; bus.Ack = 1'b0;
        bus.pipe_idx = 3'd2; bus.coin_idx = 3'd2;
        set_far();
        tick(); tick();
        reset = 1'b0;
        tick();

        // Pipe index steps 2->3->4->0 with the bird safely in the gap.
        start_run();
        tick();
        step_pipe(1); tick();
        step_pipe(1); tick();
        step_pipe(1); tick();

        // Walk the score to 99, wrap to 00, then two more.
        step_pipe(96);
        step_pipe(1);
        step_pipe(2);

        // Pipe collision above the gap.
        bus.pipe_xl = 10'd200; bus.pipe_xr = 10'd261; bus.bird_y = 10'd140;
        tick();
        set_far();
        tick(); tick();
        bus.Ack = 1'b1; tick(); bus.Ack = 1'b0;
        tick();
        start_run();

        // Ground: 447 is clear, 449 touches.
        bus.bird_y = 10'd447; tick(); tick(); tick();
        bus.bird_y = 10'd449; tick();
        bus.bird_y = 10'd200; tick();
        bus.Ack = 1'b1; tick(); bus.Ack = 1'b0;
        start_run();

        // Coin overlapping the bird for 10 cycles, then recycled.
        bus.coin_xl = 10'd215; bus.coin_xr = 10'd225;
        bus.coin_yt = 10'd205; bus.coin_yb = 10'd215;
        for (int k = 0; k < 10; k++) tick();
        set_far();
        bus.coin_idx = 3'd3; tick(); tick();

        // Reset in the middle of a run.
        step_pipe(5);
        reset = 1'b1; tick();
        reset = 1'b0; tick(); tick();

        // Randomized play.
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            bus.Start = ($urandom_range(0, 3) == 0);
            bus.Ack   = ($urandom_range(0, 3) == 0);
            bus.bird_y  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(440, 470))
                                                       : 10'($urandom_range(140, 300));
            bus.gap_top = 10'($urandom_range(120, 170));
            bus.gap_bot = 10'($urandom_range(290, 330));
            if ($urandom_range(0, 1) == 0) begin
                bus.pipe_xl = 10'd400; bus.pipe_xr = 10'd461;
            end else begin
                bus.pipe_xl = 10'($urandom_range(140, 260));
                bus.pipe_xr = bus.pipe_xl + 10'd60;
            end
            if ($urandom_range(0, 5) == 0)
                bus.pipe_idx = 3'((int'(bus.pipe_idx) + 1) % 5);
            if ($urandom_range(0, 5) == 0)
                bus.coin_idx = 3'((int'(bus.coin_idx) + 1) % 5);
            bus.coin_xl = 10'($urandom_range(190, 240));
            bus.coin_xr = bus.coin_xl + 10'd10;
            bus.coin_yt = 10'(int'(bus.bird_y) + $urandom_range(0, 30) - 15);
            bus.coin_yb = bus.coin_yt + 10'd10;
            tick();
        end

        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
